// File: rtl/dsp48e_cmult_unpack_acc.sv
// Unpacks the three partial-product fields of a packed DSP48E P word and integrates each per frame.
// Define CMULT_UNPACK_ACC_SATURATE_EN to clamp accumulators at full scale instead of wrapping.
module dsp48e_cmult_unpack_acc #(
    parameter int BITWIDTH     = 4,
    parameter int FIELD_SHIFT  = 13,
    parameter int FIELD_WIDTH  = 2*BITWIDTH+1,
    parameter int ACC_WIDTH    = 24,
    parameter int PIPE_LATENCY = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [47:0]          pout,
    output logic [ACC_WIDTH-1:0] acc_lo,
    output logic [ACC_WIDTH-1:0] acc_mid,
    output logic [ACC_WIDTH-1:0] acc_hi,
    output logic [CNT_WIDTH-1:0] acc_count,
    output logic                 out_valid,
    output logic                 out_ovf
);

`ifdef CMULT_UNPACK_ACC_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    typedef enum logic {EMPTY, ACCUM} state_t;

    state_t                 state;
    logic [PIPE_LATENCY-1:0] vld_dly;
    logic [PIPE_LATENCY-1:0] lst_dly;
    logic [ACC_WIDTH-1:0]   acc0, acc1, acc2;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   ovf;

    logic                   v_d, l_d, in_frame;
    logic [ACC_WIDTH:0]     f0, f1, f2;
    logic [ACC_WIDTH:0]     s0, s1, s2;
    logic [CNT_WIDTH:0]     cnt_s;
    logic                   ovf_n;
    logic                   unused_pout;

    // Carry bit of the widened sum either clamps the result or is dropped.
    function automatic logic [ACC_WIDTH-1:0] settle(input logic [ACC_WIDTH:0] s);
        settle = (SATURATE && s[ACC_WIDTH]) ? '1 : s[ACC_WIDTH-1:0];
    endfunction

    assign v_d      = vld_dly[PIPE_LATENCY-1];
    assign l_d      = lst_dly[PIPE_LATENCY-1];
    assign in_frame = (state == ACCUM);

    // Field extraction: every field is zero-extended with one spare carry bit.
    assign f0 = (ACC_WIDTH+1)'(pout[FIELD_WIDTH-1:0]);
    assign f1 = (ACC_WIDTH+1)'(pout[FIELD_SHIFT+FIELD_WIDTH-1:FIELD_SHIFT]);
    assign f2 = (ACC_WIDTH+1)'(pout[2*FIELD_SHIFT+FIELD_WIDTH-1:2*FIELD_SHIFT]);
    assign unused_pout = ^pout;

    // A new frame adds onto zero, so EMPTY and ACCUM share one adder path.
    assign s0    = {1'b0, (in_frame ? acc0 : '0)} + f0;
    assign s1    = {1'b0, (in_frame ? acc1 : '0)} + f1;
    assign s2    = {1'b0, (in_frame ? acc2 : '0)} + f2;
    assign cnt_s = {1'b0, (in_frame ? cnt : '0)} + (CNT_WIDTH+1)'(1);
    assign ovf_n = (in_frame & ovf) | s0[ACC_WIDTH] | s1[ACC_WIDTH] | s2[ACC_WIDTH]
                 | cnt_s[CNT_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            vld_dly   <= '0;
            lst_dly   <= '0;
            acc0      <= '0;
            acc1      <= '0;
            acc2      <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            acc_lo    <= '0;
            acc_mid   <= '0;
            acc_hi    <= '0;
            acc_count <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            // Strobe alignment with the multiplier latency; a stray last is masked here.
            vld_dly   <= PIPE_LATENCY'({vld_dly, in_valid});
            lst_dly   <= PIPE_LATENCY'({lst_dly, in_valid & in_last});
            out_valid <= 1'b0;
            if (v_d) begin
                acc0 <= settle(s0);
                acc1 <= settle(s1);
                acc2 <= settle(s2);
                cnt  <= cnt_s[CNT_WIDTH-1:0];
                ovf  <= ovf_n;
                if (l_d) begin
                    // Frame close: publish totals including this sample.
                    acc_lo    <= settle(s0);
                    acc_mid   <= settle(s1);
                    acc_hi    <= settle(s2);
                    acc_count <= cnt_s[CNT_WIDTH-1:0];
                    out_ovf   <= ovf_n;
                    out_valid <= 1'b1;
                    state     <= EMPTY;
                end else begin
                    state <= ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp48e_cmult_unpack_acc.sv
// Bench for dsp48e_cmult_unpack_acc: directed and random frames against a frame-level sum model.
module tb_dsp48e_cmult_unpack_acc;
    localparam int BW = 4;
    localparam int FS = 13;
    localparam int FW = 2*BW+1;
    localparam int AW = 10;
    localparam int PL = 4;
    localparam int CW = 16;
    localparam longint AMOD = longint'(1) << AW;

    logic          clk, rst_n, in_valid, in_last;
    logic [47:0]   pout;
    logic [AW-1:0] acc_lo, acc_mid, acc_hi;
    logic [CW-1:0] acc_count;
    logic          out_valid, out_ovf;

    dsp48e_cmult_unpack_acc #(
        .BITWIDTH(BW), .FIELD_SHIFT(FS), .FIELD_WIDTH(FW),
        .ACC_WIDTH(AW), .PIPE_LATENCY(PL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .pout(pout),
        .acc_lo(acc_lo), .acc_mid(acc_mid), .acc_hi(acc_hi), .acc_count(acc_count),
        .out_valid(out_valid), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned   due;
        logic [AW-1:0] e0, e1, e2;
        logic [CW-1:0] ec;
        logic          eovf;
    } exp_t;

    exp_t          expq[$];
    int            nvec = 0;
    int            nerr = 0;
    int unsigned   cyc = 0;
    logic [47:0]   ph[PL];
    longint        sum0, sum1, sum2;
    int            fcnt = 0;
    logic [AW-1:0] hold0 = '0, hold1 = '0, hold2 = '0;
    logic [CW-1:0] holdc = '0;
    logic          holdo = 1'b0;

    function automatic logic [47:0] mk(input int hi, input int mid, input int lo);
        mk = (48'(hi) << (2*FS)) | (48'(mid) << FS) | 48'(lo);
    endfunction

    function automatic longint fld(input logic [47:0] p, input int k);
        fld = (longint'(p) >> (k*FS)) & ((longint'(1) << FW) - 1);
    endfunction

    function automatic logic [AW-1:0] fold(input longint s);
`ifdef CMULT_UNPACK_ACC_SATURATE_EN
        if (s >= AMOD) return AW'(AMOD - 1);
`endif
        return AW'(s % AMOD);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("out_valid", 64'(out_valid), 64'd1);
            hold0 = expq[0].e0;
            hold1 = expq[0].e1;
            hold2 = expq[0].e2;
            holdc = expq[0].ec;
            holdo = expq[0].eovf;
            void'(expq.pop_front());
        end else begin
            chk("out_valid_idle", 64'(out_valid), 64'd0);
        end
        chk("acc_lo", 64'(acc_lo), 64'(hold0));
        chk("acc_mid", 64'(acc_mid), 64'(hold1));
        chk("acc_hi", 64'(acc_hi), 64'(hold2));
        chk("acc_count", 64'(acc_count), 64'(holdc));
        chk("out_ovf", 64'(out_ovf), 64'(holdo));
    endtask

    // One clock: check what the DUT shows now, then present this cycle's sample.
    task automatic step(input logic v, input logic l, input logic [47:0] p);
        exp_t e;
        @(negedge clk);
        check_outputs();
        in_valid = v;
        in_last  = l;
        pout     = ph[PL-1];
        for (int i = PL-1; i > 0; i--) ph[i] = ph[i-1];
        ph[0] = p;
        if (v) begin
            if (fcnt == 0) begin
                sum0 = 0; sum1 = 0; sum2 = 0;
            end
            sum0 += fld(p, 0);
            sum1 += fld(p, 1);
            sum2 += fld(p, 2);
            fcnt++;
            if (l) begin
                e.due  = cyc + PL + 1;
                e.e0   = fold(sum0);
                e.e1   = fold(sum1);
                e.e2   = fold(sum2);
                e.ec   = CW'(fcnt);
                e.eovf = (sum0 >= AMOD) || (sum1 >= AMOD) || (sum2 >= AMOD)
                      || (fcnt >= (1 << CW));
                expq.push_back(e);
                fcnt = 0;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 48'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        pout     = '0;
        for (int i = 0; i < PL; i++) ph[i] = '0;
        fcnt = 0;
        expq.delete();
        hold0 = '0; hold1 = '0; hold2 = '0; holdc = '0; holdo = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [47:0] pa, pg, p;
        logic        v, l;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        pout     = '0;
        for (int i = 0; i < PL; i++) ph[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        pa = mk(3, 17, 10);
        step(1'b1, 1'b1, pa);
        idle(7);

        step(1'b1, 1'b0, pa); idle(1);
        step(1'b1, 1'b0, pa); idle(2);
        step(1'b1, 1'b0, pa); idle(1);
        step(1'b1, 1'b1, pa);
        idle(7);

        step(1'b1, 1'b0, pa);
        step(1'b1, 1'b1, pa);
        step(1'b1, 1'b1, mk(3, 2, 1));
        idle(7);

        pg = mk(7, 6, 5) | (48'hF << 22) | (48'h1FFF << 35) | (48'hF << 9);
        step(1'b1, 1'b1, pg);
        idle(7);

        step(1'b1, 1'b0, mk(0, 511, 0));
        step(1'b1, 1'b0, mk(0, 511, 0));
        step(1'b1, 1'b1, mk(0, 511, 0));
        idle(7);

        step(1'b1, 1'b0, pa);
        step(1'b1, 1'b0, pa);
        do_reset();
        idle(1);
        step(1'b1, 1'b1, pa);
        idle(7);

        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 2) != 0);
            l = ($urandom_range(0, 4) == 0);
            p = {16'($urandom), 32'($urandom)};
            step(v, l, p);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
